pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of cycles pll_resetb is held low per PLL reset pulse.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before system release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: timeouts tolerated before FAULT.
REQ-005 SHALL have ports, in order: clock_in input 1 (reference clock, the only clock); reset input 1 (synchronous, active-high); pll_locked input 1 (raw PLL LOCK, asynchronous); restart input 1 (single-cycle request to re-run the sequence); pll_resetb output 1 (drives PLL RESETB); pll_bypass output 1 (drives PLL BYPASS); sys_reset output 1 (active-high reset for PLL-clocked logic); ready output 1; fault output 1; retry_count output 2.

Function
REQ-006 SHALL pass pll_locked through a 2-flop synchroniser; lock_s is the second flop output.
REQ-007 SHALL implement states PLL_RST, WAIT_LOCK, STABILIZE, RUN, FAULT; all outputs SHALL be registered.
REQ-008 PLL_RST: pll_resetb=0 for exactly RESET_CYCLES cycles, then WAIT_LOCK.
REQ-009 WAIT_LOCK: pll_resetb=1; lock_s=1 -> STABILIZE with the counter cleared; counter reaching TIMEOUT_CYCLES-1 -> retry_count+1, then FAULT if the new value equals MAX_RETRIES, else PLL_RST.
REQ-010 STABILIZE: lock_s=0 -> WAIT_LOCK with the timeout counter restarted; STABLE_CYCLES consecutive lock_s=1 -> RUN.
REQ-011 sys_reset SHALL deassert exactly 2+STABLE_CYCLES edges after the first edge sampling pll_locked=1, provided the lock stays high.
REQ-012 RUN: sys_reset=0, ready=1; lock_s=0 -> PLL_RST, with sys_reset=1 and ready=0 on the next edge.
REQ-013 FAULT: fault=1, pll_bypass=1, pll_resetb=1, sys_reset=0; the system runs on bypassed reference clock; state held until restart or reset.
REQ-014 restart=1 in any state -> PLL_RST on the next edge, counter and retry_count cleared, pll_bypass=0, fault=0, sys_reset=1; restart takes priority over simultaneous lock/timeout events.
REQ-015 retry_count SHALL saturate at MAX_RETRIES and clear only on reset or restart.
REQ-016 Counter width SHALL be $clog2 of the largest of RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES, plus 1; the counter SHALL never wrap.

Reset
REQ-017 reset SHALL force: state PLL_RST, pll_resetb=0, pll_bypass=0, sys_reset=1, ready=0, fault=0, retry_count=0, counter 0, synchroniser flops 0.
REQ-018 reset asserted mid-sequence SHALL abort the sequence on the same edge; the PLL reset pulse restarts at full length.

Configuration
REQ-019 With LOCK_LOSS_COUNT_EN defined, SHALL add output lock_loss_count (8 bits), incremented on each RUN->PLL_RST lock loss, saturating at 255, cleared only by reset.
REQ-020 Without LOCK_LOSS_COUNT_EN, the port and its counter SHALL be absent.

Structure
REQ-021 State enum and the saturate-increment helper SHALL live in package pll_seq_pkg.
REQ-022 The synchroniser SHALL be sub-module sync_2ff (1-bit, reset value 0).

Verification (RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-023 Reset release, pll_locked high 10 cycles later and held -> pll_resetb low exactly 4 cycles; sys_reset falls 10 edges after lock sampled; ready=1.
REQ-024 pll_locked never high -> two 4-cycle resetb pulses 32 cycles apart; retry_count 1 then 2; fault=1, pll_bypass=1, sys_reset=0.
REQ-025 Lock glitch low 1 cycle at STABILIZE cycle 5 -> return to WAIT_LOCK; sys_reset still 1; release occurs 8 full stable cycles later.
REQ-026 Lock drop in RUN -> sys_reset=1 and ready=0 within 3 edges; new 4-cycle resetb pulse; lock_loss_count 0->1 (macro defined).
REQ-027 restart in FAULT on the same edge as a timeout -> PLL_RST, retry_count=0, fault=0, pll_bypass=0.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding and a
// saturating increment used by the retry and lock-loss counters.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } seq_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
    return (value >= limit) ? limit : value + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear on reset.
module sync_2ff (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: pulses PLL RESETB, waits for a stable lock, then releases
// the system reset; retries on timeout and falls back to bypass. Optional LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int MAX_A      = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic [1:0]    next_retry;

  sync_2ff u_lock_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (pll_locked),
    .q        (lock_s)
  );

  assign next_retry = 2'(sat_inc(8'(retry_count), 8'(RETRY_MAX)));

  // Every counter compare stops at its last value and clears, so cnt never wraps.
  always_ff @(posedge clock_in) begin
    if (reset || restart) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= 2'd0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt         <= '0;
            retry_count <= next_retry;
            if (next_retry == RETRY_MAX) begin
              state      <= FAULT;
              fault      <= 1'b1;
              pll_bypass <= 1'b1;
              sys_reset  <= 1'b0;
            end else begin
              state      <= PLL_RST;
              pll_resetb <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STABILIZE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
          end
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state      <= PLL_RST;
          cnt        <= '0;
          pll_resetb <= 1'b0;
          pll_bypass <= 1'b0;
          sys_reset  <= 1'b1;
          ready      <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  // A restart out of RUN is a request, not a lock loss, so it is not counted.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_loss_count <= 8'd0;
    end else if (state == RUN && !lock_s && !restart) begin
      lock_loss_count <= sat_inc(lock_loss_count, 8'd255);
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues the expected output
// transitions (cycle + value); a negedge monitor checks every observed change.
module tb_pll_reset_sequencer;

  localparam int RESET_CYCLES   = 4;
  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int MAX_RETRIES    = 2;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       restart;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  pll_reset_sequencer #(
    .RESET_CYCLES   (RESET_CYCLES),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [6:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         tests    = 0;
  int         failures = 0;
  bit         mon_en   = 1'b0;
  logic [6:0] prev;
  logic [6:0] obs;

  assign obs = {pll_resetb, pll_bypass, sys_reset, ready, fault, retry_count};

  function automatic logic [6:0] pack(input bit rb, input bit byp, input bit sr,
                                      input bit rdy, input bit flt, input logic [1:0] rc);
    return {rb, byp, sr, rdy, flt, rc};
  endfunction

  task automatic expect_at(input int at, input logic [6:0] val);
    exp_q.push_back('{at, val});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock_in);
  endtask

  task automatic apply_stimulus(input bit rst, input bit lock, input bit rs);
    reset      = rst;
    pll_locked = lock;
    restart    = rs;
  endtask

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %b, required %b", name, cyc, got, want);
    end
  endtask

  // Monitor: any change of the output vector must match the head of the queue.
  always @(negedge clock_in) begin
    if (mon_en && obs !== prev) begin
      prev = obs;
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_change at cycle %0d: got %b, required no change", cyc, obs);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (e.at != cyc) begin
          failures++;
          $display("[TB] FAIL event_timing: got cycle %0d, required cycle %0d (value %b)", cyc, e.at, e.val);
        end
        tests++;
        if (obs !== e.val) begin
          failures++;
          $display("[TB] FAIL event_value at cycle %0d: got %b, required %b", cyc, obs, e.val);
        end
      end
    end
  end

  initial begin
    int r, d, a, e0, f;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_until(3);
    check_output("reset_state", {1'b0, obs}, {1'b0, pack(0, 0, 1, 0, 0, 2'd0)});
`ifdef LOCK_LOSS_COUNT_EN
    check_output("lock_loss_reset", lock_loss_count, 8'd0);
`endif
    prev   = obs;
    mon_en = 1'b1;

    // Clean power-up: lock arrives 10 cycles after reset release
    r = cyc;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    expect_at(r + 4, pack(1, 0, 1, 0, 0, 2'd0));
    wait_until(r + 10);
    pll_locked = 1'b1;
    expect_at(r + 21, pack(1, 0, 0, 1, 0, 2'd0));
    wait_until(r + 25);

    // Lock loss while running, then relock
    d = cyc;
`ifdef LOCK_LOSS_COUNT_EN
    check_output("lock_loss_before", lock_loss_count, 8'd0);
`endif
    pll_locked = 1'b0;
    expect_at(d + 3, pack(0, 0, 1, 0, 0, 2'd0));
    expect_at(d + 7, pack(1, 0, 1, 0, 0, 2'd0));
    wait_until(d + 7);
    pll_locked = 1'b1;
    expect_at(d + 18, pack(1, 0, 0, 1, 0, 2'd0));
    wait_until(d + 20);
`ifdef LOCK_LOSS_COUNT_EN
    check_output("lock_loss_after", lock_loss_count, 8'd1);
`endif

    // One-cycle lock glitch in the fifth stabilise cycle
    a = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    expect_at(a + 1, pack(0, 0, 1, 0, 0, 2'd0));
    wait_until(a + 1);
    r = a + 1;
    reset = 1'b0;
    expect_at(r + 4, pack(1, 0, 1, 0, 0, 2'd0));
`ifdef LOCK_LOSS_COUNT_EN
    check_output("lock_loss_cleared", lock_loss_count, 8'd0);
`endif
    wait_until(r + 10);
    pll_locked = 1'b1;
    e0 = r + 11;
    wait_until(e0 + 4);
    pll_locked = 1'b0;
    wait_until(e0 + 5);
    pll_locked = 1'b1;
    expect_at(e0 + 16, pack(1, 0, 0, 1, 0, 2'd0));
    wait_until(e0 + 20);

    // Lock never arrives: two retries then fault/bypass
    a = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    expect_at(a + 1, pack(0, 0, 1, 0, 0, 2'd0));
    wait_until(a + 1);
    r = a + 1;
    reset = 1'b0;
    expect_at(r + 4,  pack(1, 0, 1, 0, 0, 2'd0));
    expect_at(r + 36, pack(0, 0, 1, 0, 0, 2'd1));
    expect_at(r + 40, pack(1, 0, 1, 0, 0, 2'd1));
    expect_at(r + 72, pack(1, 1, 0, 0, 1, 2'd2));
    wait_until(r + 75);

    // Restart out of FAULT, then restart colliding with the final timeout
    f = cyc;
    restart = 1'b1;
    expect_at(f + 1, pack(0, 0, 1, 0, 0, 2'd0));
    wait_until(f + 1);
    restart = 1'b0;
    expect_at(f + 5,  pack(1, 0, 1, 0, 0, 2'd0));
    expect_at(f + 37, pack(0, 0, 1, 0, 0, 2'd1));
    expect_at(f + 41, pack(1, 0, 1, 0, 0, 2'd1));
    wait_until(f + 72);
    restart = 1'b1;
    expect_at(f + 73, pack(0, 0, 1, 0, 0, 2'd0));
    wait_until(f + 73);
    restart = 1'b0;

    // Reset in the middle of a RESETB pulse restarts it at full length
    wait_until(f + 74);
    reset = 1'b1;
    wait_until(f + 75);
    reset = 1'b0;
    expect_at(f + 79, pack(1, 0, 1, 0, 0, 2'd0));
    wait_until(f + 79);
    pll_locked = 1'b1;
    expect_at(f + 90, pack(1, 0, 0, 1, 0, 2'd0));
    wait_until(f + 95);

    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_events: got %0d events left pending, required 0 (next due cycle %0d)",
               exp_q.size(), exp_q[0].at);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
